cc_flag_unit: RTL

Producer side of the condition-code interface. It computes OF/ZF/SF from each Y86-64 OPq result and holds them in a speculative CC register, which drives the 3-bit flag bus read by the condition evaluator for jXX/cmovXX. It also tracks in-flight flag updates through the M and W stages. A committed copy is kept, and the speculative flags are restored from it on a pipeline flush.

---
 rtl/cc_flag_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cc_flag_unit.sv
// Condition-code producer: computes {SF,ZF,OF} per OPq result, tracks M/W in-flight updates
// and keeps a committed copy for flush recovery. Define CC_FWD_EN for a same-cycle cc_out bypass.
module cc_flag_unit #(
    parameter int          WIDTH    = 64,
    parameter logic [2:0]  RESET_CC = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_e,
    input  logic [3:0]       alu_fun,
    input  logic             set_cc,
    input  logic             stall,
    input  logic             flush,
    input  logic             w_ok,
    output logic [2:0]       cc_out,
    output logic [2:0]       cc_commit,
    output logic             cc_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND1 = 2'd1,
        PEND2 = 2'd2
    } state_t;

    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_SUB = 4'd1;
    localparam logic [3:0] FUN_MAX = 4'd3;

    state_t     r_state;
    state_t     w_state_next;

    logic [2:0] r_cc_spec;
    logic [2:0] r_cc_commit;
    logic       r_m_valid;
    logic [2:0] r_m_flags;
    logic       r_w_valid;
    logic [2:0] r_w_flags;

    logic       w_a_msb;
    logic       w_b_msb;
    logic       w_e_msb;
    logic       w_zf;
    logic       w_of;
    logic [2:0] w_flags;
    logic       w_upd;
    logic [2:0] w_commit_next;
    logic       w_m_valid_next;
    logic       w_w_valid_next;

    assign w_a_msb = alu_a[WIDTH-1];
    assign w_b_msb = alu_b[WIDTH-1];
    assign w_e_msb = alu_e[WIDTH-1];
    assign w_zf    = (alu_e == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_of = 1'b0;
        case (alu_fun)
            FUN_ADD: w_of = (w_a_msb == w_b_msb) && (w_e_msb != w_a_msb);
            FUN_SUB: w_of = (w_a_msb != w_b_msb) && (w_e_msb != w_b_msb);
            default: w_of = 1'b0;
        endcase
    end

    assign w_flags = {w_e_msb, w_zf, w_of};
    assign w_upd   = set_cc && !stall && !flush && (alu_fun <= FUN_MAX);

    // W is consumed every cycle it is valid: committed on w_ok, dropped otherwise.
    assign w_commit_next = (r_w_valid && w_ok) ? r_w_flags : r_cc_commit;

    always_comb begin
        w_m_valid_next = r_m_valid;
        w_w_valid_next = 1'b0;
        if (flush) begin
            w_m_valid_next = 1'b0;
            w_w_valid_next = 1'b0;
        end else if (!stall) begin
            w_m_valid_next = w_upd;
            w_w_valid_next = r_m_valid;
        end
    end

    always_comb begin
        w_state_next = IDLE;
        case ({w_m_valid_next, w_w_valid_next})
            2'b11:        w_state_next = PEND2;
            2'b10, 2'b01: w_state_next = PEND1;
            default:      w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cc_spec   <= RESET_CC;
            r_cc_commit <= RESET_CC;
            r_m_valid   <= 1'b0;
            r_m_flags   <= 3'b000;
            r_w_valid   <= 1'b0;
            r_w_flags   <= 3'b000;
        end else begin
            r_state     <= w_state_next;
            r_cc_commit <= w_commit_next;
            r_m_valid   <= w_m_valid_next;
            r_w_valid   <= w_w_valid_next;
            if (!stall) begin
                r_m_flags <= w_flags;
                r_w_flags <= r_m_flags;
            end
            // Flush restores from the post-edge committed value, so a same-edge commit is kept.
            if (flush) begin
                r_cc_spec <= w_commit_next;
            end else if (w_upd) begin
                r_cc_spec <= w_flags;
            end
        end
    end

`ifdef CC_FWD_EN
    assign cc_out = w_upd ? w_flags : r_cc_spec;
`else
    assign cc_out = r_cc_spec;
`endif

    assign cc_commit = r_cc_commit;
    assign cc_busy   = (r_state != IDLE);

endmodule
